// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HELD,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_skid.sv
// One-entry instruction buffer: holds a word that arrived while downstream was stalled.
module fetch_skid
   import fetch_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic            drop_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] data_q;

   // Buffer register: drop clears, load captures, otherwise hold.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else if (drop_i) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= data_i;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, imem req/ack sequencing, stall skid and
// redirect handling. Optional macro FETCH_MISALIGN_TRAP_EN enables the sticky
// misaligned-redirect trap; otherwise redirect targets are word-aligned by force.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            stallF,
   input  logic            redirectE,
   input  logic [XLEN-1:0] PCTargetE,
   fetch_unit_if.master    imem,
   output logic [XLEN-1:0] insF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
   output logic            validF,
   output logic            misalignF
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] stale_q, stale_d;   // address of the request being drained
   logic [XLEN-1:0] ins_q, ins_d;
   logic [XLEN-1:0] pcf_q, pcf_d;
   logic [XLEN-1:0] pcp4_q, pcp4_d;
   logic            valid_q, valid_d;
   logic            misalign_q, misalign_d;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ack;
   logic [XLEN-1:0] pc_next, pc_prev;
   logic [XLEN-1:0] target;
   logic            target_misalign;
   logic            skid_load, skid_drop;
   logic [XLEN-1:0] skid_data;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target          = PCTargetE;
   assign target_misalign = |PCTargetE[1:0];
`else
   assign target          = PCTargetE & 32'hFFFF_FFFC;
   assign target_misalign = 1'b0;
`endif

   assign pc_next = pc_q + PC_STEP;
   assign pc_prev = pc_q - PC_STEP;

   fetch_skid u_skid (
      .clk_i  (CLK),
      .rst_ni (reset),
      .load_i (skid_load),
      .drop_i (skid_drop),
      .data_i (imem.imem_rdata),
      .data_o (skid_data)
   );

   // Request decode: DRAIN keeps the stale request alive until its ack arrives.
   always_comb begin
      req  = 1'b0;
      addr = pc_q;
      unique case (state_q)
         REQ:   req = !misalign_q;
         DRAIN: begin
            req  = 1'b1;
            addr = stale_q;
         end
         default: req = 1'b0;
      endcase
   end

   // An ack only counts while a request is actually up.
   assign ack = imem.imem_ack && req;

   // Next-state logic: redirect beats everything, including stall.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      stale_d    = stale_q;
      ins_d      = ins_q;
      pcf_d      = pcf_q;
      pcp4_d     = pcp4_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;
      skid_load  = 1'b0;
      skid_drop  = 1'b0;

      if (redirectE) begin
         pc_d       = target;
         valid_d    = 1'b0;
         misalign_d = target_misalign;
         skid_drop  = 1'b1;
         unique case (state_q)
            REQ: begin
               stale_d = pc_q;
               state_d = (req && !ack) ? DRAIN : REQ;
            end
            DRAIN:   state_d = ack ? REQ : DRAIN;
            default: state_d = REQ;
         endcase
      end else begin
         unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (ack) begin
                  pc_d = pc_next;
                  if (!valid_q || !stallF) begin
                     ins_d   = imem.imem_rdata;
                     pcf_d   = pc_q;
                     pcp4_d  = pc_next;
                     valid_d = 1'b1;
                  end else begin
                     skid_load = 1'b1;
                     state_d   = HELD;
                  end
               end else if (!stallF) begin
                  valid_d = 1'b0;
               end
            end
            HELD: begin
               if (!stallF) begin
                  ins_d     = skid_data;
                  pcf_d     = pc_prev;
                  pcp4_d    = pc_q;
                  valid_d   = 1'b1;
                  skid_drop = 1'b1;
                  state_d   = REQ;
               end
            end
            DRAIN: begin
               if (ack) begin
                  state_d = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         stale_q    <= '0;
         ins_q      <= '0;
         pcf_q      <= '0;
         pcp4_q     <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         stale_q    <= stale_d;
         ins_q      <= ins_d;
         pcf_q      <= pcf_d;
         pcp4_q     <= pcp4_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = addr;
   assign insF           = ins_q;
   assign PCF            = pcf_q;
   assign PCPlus4F       = pcp4_q;
   assign validF         = valid_q;
   assign misalignF      = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand sequences for reset and misalign.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] C = 32'hA5A5_0000;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] target;
      logic        ack;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pcf;
      logic [31:0] exp_pcp4;
   } vec_t;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        stallF = 1'b0;
   logic        redirectE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic [31:0] insF, PCF, PCPlus4F;
   logic        validF, misalignF;

   int checks = 0;
   int errors = 0;

   vec_t vecs [30];

   fetch_unit_if imem_bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .CLK       (CLK),
      .reset     (reset),
      .stallF    (stallF),
      .redirectE (redirectE),
      .PCTargetE (PCTargetE),
      .imem      (imem_bus),
      .insF      (insF),
      .PCF       (PCF),
      .PCPlus4F  (PCPlus4F),
      .validF    (validF),
      .misalignF (misalignF)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                               input logic a, input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep, input logic [31:0] ep4);
      vec_t v;
      v.stall = s; v.redir = r; v.target = t; v.ack = a;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pcf = ep; v.exp_pcp4 = ep4;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = '0;

      //      stall redir target        ack  req addr          valid pcf           pcp4
      vecs[0]  = mk(0, 0, 32'h0,        0,   0, 32'h0,         0, 32'h0,         32'h0);
      vecs[1]  = mk(0, 0, 32'h0,        1,   1, 32'h0,         0, 32'h0,         32'h0);
      vecs[2]  = mk(0, 0, 32'h0,        0,   1, 32'h4,         1, 32'h0,         32'h4);
      vecs[3]  = mk(0, 0, 32'h0,        0,   1, 32'h4,         0, 32'h0,         32'h0);
      vecs[4]  = mk(0, 0, 32'h0,        0,   1, 32'h4,         0, 32'h0,         32'h0);
      vecs[5]  = mk(0, 0, 32'h0,        1,   1, 32'h4,         0, 32'h0,         32'h0);
      vecs[6]  = mk(1, 0, 32'h0,        1,   1, 32'h8,         1, 32'h4,         32'h8);
      vecs[7]  = mk(1, 0, 32'h0,        0,   0, 32'h0,         1, 32'h4,         32'h8);
      vecs[8]  = mk(0, 0, 32'h0,        0,   0, 32'h0,         1, 32'h4,         32'h8);
      vecs[9]  = mk(0, 0, 32'h0,        1,   1, 32'hC,         1, 32'h8,         32'hC);
      vecs[10] = mk(0, 0, 32'h0,        0,   1, 32'h10,        1, 32'hC,         32'h10);
      vecs[11] = mk(0, 1, 32'h100,      0,   1, 32'h10,        0, 32'h0,         32'h0);
      vecs[12] = mk(0, 0, 32'h0,        1,   1, 32'h10,        0, 32'h0,         32'h0);
      vecs[13] = mk(0, 0, 32'h0,        1,   1, 32'h100,       0, 32'h0,         32'h0);
      vecs[14] = mk(0, 1, 32'h200,      1,   1, 32'h104,       1, 32'h100,       32'h104);
      vecs[15] = mk(0, 0, 32'h0,        1,   1, 32'h200,       0, 32'h0,         32'h0);
      vecs[16] = mk(1, 0, 32'h0,        1,   1, 32'h204,       1, 32'h200,       32'h204);
      vecs[17] = mk(1, 1, 32'h300,      0,   0, 32'h0,         1, 32'h200,       32'h204);
      vecs[18] = mk(1, 0, 32'h0,        1,   1, 32'h300,       0, 32'h0,         32'h0);
      vecs[19] = mk(1, 0, 32'h0,        0,   1, 32'h304,       1, 32'h300,       32'h304);
      vecs[20] = mk(0, 0, 32'h0,        0,   1, 32'h304,       1, 32'h300,       32'h304);
      vecs[21] = mk(0, 0, 32'h0,        1,   1, 32'h304,       0, 32'h0,         32'h0);
      vecs[22] = mk(0, 1, 32'h107,      0,   1, 32'h308,       1, 32'h304,       32'h308);
      vecs[23] = mk(0, 1, 32'h400,      0,   1, 32'h308,       0, 32'h0,         32'h0);
      vecs[24] = mk(0, 0, 32'h0,        1,   1, 32'h308,       0, 32'h0,         32'h0);
      vecs[25] = mk(0, 0, 32'h0,        1,   1, 32'h400,       0, 32'h0,         32'h0);
      vecs[26] = mk(0, 1, 32'hFFFF_FFFC, 0,  1, 32'h404,       1, 32'h400,       32'h404);
      vecs[27] = mk(0, 0, 32'h0,        1,   1, 32'h404,       0, 32'h0,         32'h0);
      vecs[28] = mk(0, 0, 32'h0,        1,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
      vecs[29] = mk(0, 0, 32'h0,        0,   1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0);

      // Reset state.
      tick();
      tick();
      check("rst req", {31'b0, imem_bus.imem_req}, 32'h0);
      check("rst valid", {31'b0, validF}, 32'h0);
      check("rst misalign", {31'b0, misalignF}, 32'h0);
      check("rst insF", insF, 32'h0);
      check("rst PCF", PCF, 32'h0);
      check("rst PCPlus4F", PCPlus4F, 32'h0);
      reset = 1'b1;

      // Main table: sample registered outputs, then drive this cycle's inputs.
      for (int i = 0; i < 30; i++) begin
         check($sformatf("row%0d req", i), {31'b0, imem_bus.imem_req}, {31'b0, vecs[i].exp_req});
         if (vecs[i].exp_req)
            check($sformatf("row%0d addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
         check($sformatf("row%0d valid", i), {31'b0, validF}, {31'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            check($sformatf("row%0d PCF", i), PCF, vecs[i].exp_pcf);
            check($sformatf("row%0d PCPlus4F", i), PCPlus4F, vecs[i].exp_pcp4);
            check($sformatf("row%0d insF", i), insF, vecs[i].exp_pcf ^ C);
         end
         stallF              = vecs[i].stall;
         redirectE           = vecs[i].redir;
         PCTargetE           = vecs[i].target;
         imem_bus.imem_ack   = vecs[i].ack;
         imem_bus.imem_rdata = vecs[i].ack ? (vecs[i].exp_addr ^ C) : 32'hDEAD_BEEF;
         tick();
      end
      stallF    = 1'b0;
      redirectE = 1'b0;

      // Reset in the middle of an outstanding request, then a stale ack.
      check("pre-rst req", {31'b0, imem_bus.imem_req}, 32'h1);
      reset = 1'b0;
      #1;
      check("mid-rst req", {31'b0, imem_bus.imem_req}, 32'h0);
      check("mid-rst valid", {31'b0, validF}, 32'h0);
      check("mid-rst PCF", PCF, 32'h0);
      check("mid-rst insF", insF, 32'h0);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'h1234_5678;
      tick();
      reset = 1'b1;
      check("post-rst idle req", {31'b0, imem_bus.imem_req}, 32'h0);
      tick();
      check("post-rst stale valid", {31'b0, validF}, 32'h0);
      check("post-rst req", {31'b0, imem_bus.imem_req}, 32'h1);
      check("post-rst addr", imem_bus.imem_addr, 32'h0);
      imem_bus.imem_rdata = 32'h0 ^ C;
      tick();
      imem_bus.imem_ack = 1'b0;
      check("post-rst valid", {31'b0, validF}, 32'h1);
      check("post-rst PCF", PCF, 32'h0);
      check("post-rst insF", insF, C);

      // Misaligned redirect while a request to 0x4 is outstanding.
      redirectE = 1'b1;
      PCTargetE = 32'h102;
      tick();
      redirectE = 1'b0;
      check("mis drain req", {31'b0, imem_bus.imem_req}, 32'h1);
      check("mis drain addr", imem_bus.imem_addr, 32'h4);
      check("mis drain valid", {31'b0, validF}, 32'h0);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hBAD0_0004;
      tick();
      imem_bus.imem_ack = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("mis flag", {31'b0, misalignF}, 32'h1);
      check("mis req off", {31'b0, imem_bus.imem_req}, 32'h0);
      tick();
      tick();
      check("mis req still off", {31'b0, imem_bus.imem_req}, 32'h0);
      check("mis valid off", {31'b0, validF}, 32'h0);
      redirectE = 1'b1;
      PCTargetE = 32'h300;
      tick();
      redirectE = 1'b0;
      check("mis cleared", {31'b0, misalignF}, 32'h0);
      check("mis resume req", {31'b0, imem_bus.imem_req}, 32'h1);
      check("mis resume addr", imem_bus.imem_addr, 32'h300);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'h300 ^ C;
      tick();
      imem_bus.imem_ack = 1'b0;
      check("mis resume valid", {31'b0, validF}, 32'h1);
      check("mis resume PCF", PCF, 32'h300);
`else
      check("mis flag", {31'b0, misalignF}, 32'h0);
      check("aligned req", {31'b0, imem_bus.imem_req}, 32'h1);
      check("aligned addr", imem_bus.imem_addr, 32'h100);
      check("aligned valid", {31'b0, validF}, 32'h0);
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'h100 ^ C;
      tick();
      imem_bus.imem_ack = 1'b0;
      check("aligned out valid", {31'b0, validF}, 32'h1);
      check("aligned out PCF", PCF, 32'h100);
      check("aligned out insF", insF, 32'h100 ^ C);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
